// File: rtl/ram_port_arbiter.sv
// Front-end controller for a dual-port RAM: brings the RAM out of reset, then
// shares its write port and read port between two requesters with independent round-robin arbiters.
module ram_port_arbiter #(
    parameter int MEM_DEPTH  = 128,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
    parameter int DATA_WIDTH = 8,
    parameter int RST_CYCLES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,

    input  logic                  m0_req_i,
    input  logic                  m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0] m0_wdata_i,
    output logic                  m0_gnt_o,
    output logic                  m0_rvalid_o,
    output logic [DATA_WIDTH-1:0] m0_rdata_o,

    input  logic                  m1_req_i,
    input  logic                  m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0] m1_wdata_i,
    output logic                  m1_gnt_o,
    output logic                  m1_rvalid_o,
    output logic [DATA_WIDTH-1:0] m1_rdata_o,

    output logic                  ram_rst_o,
    output logic                  ram_valid_o,
    input  logic                  ram_ready_i,
    output logic                  ram_wr_en_o,
    output logic                  ram_rd_en_o,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr_o,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr_o,
    output logic [DATA_WIDTH-1:0] ram_wr_data_o,
    input  logic [DATA_WIDTH-1:0] ram_rd_data_i,
    output logic                  init_done_o
);

    typedef enum logic [1:0] {
        ST_RST      = 2'd0,
        ST_WAIT_RDY = 2'd1,
        ST_RUN      = 2'd2
    } state_t;

    localparam int CNT_WIDTH = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(RST_CYCLES - 1);

    state_t               state;
    state_t               state_next;
    logic [CNT_WIDTH-1:0] rst_cnt;
    logic [CNT_WIDTH-1:0] rst_cnt_next;
    logic                 grant_en;

    logic [1:0]           wr_cand;
    logic [1:0]           rd_cand;
    logic [1:0]           wr_gnt;
    logic [1:0]           rd_gnt;
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic                 rd_pending;
    logic                 rd_owner;

    // Both candidates asking: the pointer picks the winner; otherwise the lone candidate wins.
    function automatic logic [1:0] rr_pick(input logic [1:0] cand, input logic ptr);
        if (cand == 2'b11) begin
            return ptr ? 2'b10 : 2'b01;
        end
        return cand;
    endfunction

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= ST_RST;
            rst_cnt <= '0;
        end else begin
            state   <= state_next;
            rst_cnt <= rst_cnt_next;
        end
    end

    always_comb begin
        state_next   = state;
        rst_cnt_next = rst_cnt;
        unique case (state)
            ST_RST: begin
                if (rst_cnt == CNT_LAST) begin
                    state_next   = ST_WAIT_RDY;
                    rst_cnt_next = '0;
                end else begin
                    rst_cnt_next = rst_cnt + 1'b1;
                end
            end
            ST_WAIT_RDY: begin
                if (ram_ready_i) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                state_next = ST_RUN;
            end
            default: begin
                state_next   = ST_RST;
                rst_cnt_next = '0;
            end
        endcase
    end

    always_comb begin
        ram_rst_o   = 1'b0;
        ram_valid_o = 1'b0;
        init_done_o = 1'b0;
        grant_en    = 1'b0;
        unique case (state)
            ST_RST: begin
                ram_rst_o = 1'b1;
            end
            ST_WAIT_RDY: begin
                ram_valid_o = 1'b1;
            end
            ST_RUN: begin
                ram_valid_o = 1'b1;
                init_done_o = 1'b1;
                grant_en    = ram_ready_i;
            end
            default: begin
                ram_rst_o = 1'b1;
            end
        endcase
    end

    assign wr_cand = {m1_req_i &  m1_we_i, m0_req_i &  m0_we_i};
    assign rd_cand = {m1_req_i & ~m1_we_i, m0_req_i & ~m0_we_i};
    assign wr_gnt  = grant_en ? rr_pick(wr_cand, wr_ptr) : 2'b00;
    assign rd_gnt  = grant_en ? rr_pick(rd_cand, rd_ptr) : 2'b00;

    assign m0_gnt_o = wr_gnt[0] | rd_gnt[0];
    assign m1_gnt_o = wr_gnt[1] | rd_gnt[1];

    // A contested grant hands priority to the loser; uncontested grants leave it alone.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (grant_en && (wr_cand == 2'b11)) begin
                wr_ptr <= ~wr_ptr;
            end
            if (grant_en && (rd_cand == 2'b11)) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    always_comb begin
        ram_wr_en_o   = |wr_gnt;
        ram_wr_addr_o = '0;
        ram_wr_data_o = '0;
        if (wr_gnt[0]) begin
            ram_wr_addr_o = m0_addr_i;
            ram_wr_data_o = m0_wdata_i;
        end else if (wr_gnt[1]) begin
            ram_wr_addr_o = m1_addr_i;
            ram_wr_data_o = m1_wdata_i;
        end
    end

    always_comb begin
        ram_rd_en_o   = |rd_gnt;
        ram_rd_addr_o = '0;
        if (rd_gnt[0]) begin
            ram_rd_addr_o = m0_addr_i;
        end else if (rd_gnt[1]) begin
            ram_rd_addr_o = m1_addr_i;
        end
    end

    // The RAM registers read data, so the returning strobe is the grant delayed one cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_pending <= 1'b0;
            rd_owner   <= 1'b0;
        end else begin
            rd_pending <= |rd_gnt;
            if (|rd_gnt) begin
                rd_owner <= rd_gnt[1];
            end
        end
    end

    assign m0_rvalid_o = rd_pending & ~rd_owner;
    assign m1_rvalid_o = rd_pending &  rd_owner;
    assign m0_rdata_o  = ram_rd_data_i;
    assign m1_rdata_o  = ram_rd_data_i;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: write-first RAM responder, behavioural reference model checked
// every cycle, directed bring-up/contention/reset scenarios and a randomized traffic phase.
module tb_ram_port_arbiter;

    localparam int MEM_DEPTH  = 128;
    localparam int ADDR_WIDTH = 7;
    localparam int DATA_WIDTH = 8;
    localparam int RST_CYCLES = 2;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  m0_req = 1'b0, m0_we = 1'b0;
    logic [ADDR_WIDTH-1:0] m0_addr = '0;
    logic [DATA_WIDTH-1:0] m0_wdata = '0;
    logic                  m1_req = 1'b0, m1_we = 1'b0;
    logic [ADDR_WIDTH-1:0] m1_addr = '0;
    logic [DATA_WIDTH-1:0] m1_wdata = '0;
    logic                  m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [DATA_WIDTH-1:0] m0_rdata, m1_rdata;
    logic                  ram_rst, ram_valid, ram_wr_en, ram_rd_en, init_done;
    logic                  ram_ready = 1'b0;
    logic [ADDR_WIDTH-1:0] ram_wr_addr, ram_rd_addr;
    logic [DATA_WIDTH-1:0] ram_wr_data;
    logic [DATA_WIDTH-1:0] ram_rdata = '0;
    logic [DATA_WIDTH-1:0] ram_mem [MEM_DEPTH];

    int tests = 0;
    int fails = 0;

    int                    m_cyc;
    bit                    m_run;
    int                    fav_wr, fav_rd;
    bit                    pend;
    int                    pend_owner;
    logic [DATA_WIDTH-1:0] pend_data;
    logic [DATA_WIDTH-1:0] ref_mem [MEM_DEPTH];
    bit                    gnt_seen0, gnt_seen1;
    bit                    e_rst, e_g0, e_g1, can_grant;
    int                    ww, rw;
    logic [ADDR_WIDTH-1:0] wa, ra;
    logic [DATA_WIDTH-1:0] wd;

    ram_port_arbiter #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .RST_CYCLES(RST_CYCLES)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .m0_req_i     (m0_req),
        .m0_we_i      (m0_we),
        .m0_addr_i    (m0_addr),
        .m0_wdata_i   (m0_wdata),
        .m0_gnt_o     (m0_gnt),
        .m0_rvalid_o  (m0_rvalid),
        .m0_rdata_o   (m0_rdata),
        .m1_req_i     (m1_req),
        .m1_we_i      (m1_we),
        .m1_addr_i    (m1_addr),
        .m1_wdata_i   (m1_wdata),
        .m1_gnt_o     (m1_gnt),
        .m1_rvalid_o  (m1_rvalid),
        .m1_rdata_o   (m1_rdata),
        .ram_rst_o    (ram_rst),
        .ram_valid_o  (ram_valid),
        .ram_ready_i  (ram_ready),
        .ram_wr_en_o  (ram_wr_en),
        .ram_rd_en_o  (ram_rd_en),
        .ram_wr_addr_o(ram_wr_addr),
        .ram_rd_addr_o(ram_rd_addr),
        .ram_wr_data_o(ram_wr_data),
        .ram_rd_data_i(ram_rdata),
        .init_done_o  (init_done)
    );

    always #5 clk = ~clk;

    // Write-first RAM with registered read data, cleared while its sync reset is high.
    always @(posedge clk) begin
        if (ram_rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) ram_mem[i] <= '0;
            ram_rdata <= '0;
        end else begin
            if (ram_wr_en) ram_mem[ram_wr_addr] <= ram_wr_data;
            if (ram_rd_en)
                ram_rdata <= (ram_wr_en && ram_wr_addr == ram_rd_addr) ? ram_wr_data : ram_mem[ram_rd_addr];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase by cycles since release, arbitration by favoured index, reads by shadow memory.
    always @(negedge clk) begin
        gnt_seen0 = m0_gnt;
        gnt_seen1 = m1_gnt;
        if (!rst_n) begin
            checkOutput("reset_ram_rst", 32'(ram_rst), 1);
            checkOutput("reset_ram_valid", 32'(ram_valid), 0);
            checkOutput("reset_init_done", 32'(init_done), 0);
            checkOutput("reset_gnt", 32'({m1_gnt, m0_gnt}), 0);
            checkOutput("reset_rvalid", 32'({m1_rvalid, m0_rvalid}), 0);
            checkOutput("reset_enables", 32'({ram_rd_en, ram_wr_en}), 0);
            m_cyc  = 0;
            m_run  = 0;
            fav_wr = 0;
            fav_rd = 0;
            pend   = 0;
            for (int i = 0; i < MEM_DEPTH; i++) ref_mem[i] = '0;
        end else begin
            e_rst     = (m_cyc < RST_CYCLES);
            can_grant = m_run && ram_ready;
            ww = -1;
            rw = -1;
            if (can_grant) begin
                if (m0_req && m0_we && m1_req && m1_we) begin
                    ww = fav_wr;
                    fav_wr = 1 - ww;
                end else if (m0_req && m0_we) ww = 0;
                else if (m1_req && m1_we) ww = 1;
                if (m0_req && !m0_we && m1_req && !m1_we) begin
                    rw = fav_rd;
                    fav_rd = 1 - rw;
                end else if (m0_req && !m0_we) rw = 0;
                else if (m1_req && !m1_we) rw = 1;
            end
            e_g0 = (ww == 0) || (rw == 0);
            e_g1 = (ww == 1) || (rw == 1);
            checkOutput("ram_rst", 32'(ram_rst), 32'(e_rst));
            checkOutput("ram_valid", 32'(ram_valid), 32'(!e_rst));
            checkOutput("init_done", 32'(init_done), 32'(m_run));
            checkOutput("m0_gnt", 32'(m0_gnt), 32'(e_g0));
            checkOutput("m1_gnt", 32'(m1_gnt), 32'(e_g1));
            checkOutput("ram_wr_en", 32'(ram_wr_en), 32'(ww >= 0));
            checkOutput("ram_rd_en", 32'(ram_rd_en), 32'(rw >= 0));
            checkOutput("m0_rvalid", 32'(m0_rvalid), 32'(pend && pend_owner == 0));
            checkOutput("m1_rvalid", 32'(m1_rvalid), 32'(pend && pend_owner == 1));
            if (pend)
                checkOutput("rdata", 32'((pend_owner == 0) ? m0_rdata : m1_rdata), 32'(pend_data));
            wa = (ww == 1) ? m1_addr : m0_addr;
            wd = (ww == 1) ? m1_wdata : m0_wdata;
            ra = (rw == 1) ? m1_addr : m0_addr;
            if (ww >= 0) begin
                checkOutput("ram_wr_addr", 32'(ram_wr_addr), 32'(wa));
                checkOutput("ram_wr_data", 32'(ram_wr_data), 32'(wd));
            end
            if (rw >= 0) checkOutput("ram_rd_addr", 32'(ram_rd_addr), 32'(ra));
            if (rw >= 0) begin
                pend       = 1;
                pend_owner = rw;
                pend_data  = (ww >= 0 && wa == ra) ? wd : ref_mem[ra];
            end else begin
                pend = 0;
            end
            if (ww >= 0) ref_mem[wa] = wd;
            if (e_rst) begin
                for (int i = 0; i < MEM_DEPTH; i++) ref_mem[i] = '0;
                m_cyc++;
            end else if (!m_run && ram_ready) begin
                m_run = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int k, input logic req, input logic we,
                                 input logic [ADDR_WIDTH-1:0] addr, input logic [DATA_WIDTH-1:0] data);
        if (k == 0) begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = data;
        end else begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = data;
        end
    endtask

    task automatic bringUp();
        int n;
        rst_n = 1'b0;
        ram_ready = 1'b0;
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ram_rst) n++;
            else break;
        end
        checkOutput("bringup_rst_cycles", 32'(n), 2);
        tick();
        applyStimulus(0, 1, 1, 7'd3, 8'h09);
        @(negedge clk);
        checkOutput("bringup_no_gnt_before_run", 32'(m0_gnt), 0);
        checkOutput("bringup_valid_in_wait", 32'(ram_valid), 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0);
        ram_ready = 1'b1;
        @(negedge clk);
        checkOutput("bringup_done_in_wait", 32'(init_done), 0);
        tick();
        @(negedge clk);
        checkOutput("bringup_done_in_run", 32'(init_done), 1);
    endtask

    initial begin
        bringUp();

        // Single write then read of address 5.
        tick(); applyStimulus(0, 1, 1, 7'd5, 8'hA5);
        @(negedge clk); checkOutput("wr5_gnt", 32'(m0_gnt), 1);
        tick(); applyStimulus(0, 1, 0, 7'd5, 8'h00);
        @(negedge clk); checkOutput("rd5_gnt", 32'(m0_gnt), 1);
        tick(); applyStimulus(0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("rd5_rvalid", 32'(m0_rvalid), 1);
        checkOutput("rd5_data", 32'(m0_rdata), 32'h A5);
        checkOutput("rd5_m1_rvalid", 32'(m1_rvalid), 0);

        // Write contention on address 10.
        tick(); applyStimulus(0, 1, 1, 7'd10, 8'h11); applyStimulus(1, 1, 1, 7'd10, 8'h22);
        @(negedge clk);
        checkOutput("wc1_m0_first", 32'({m1_gnt, m0_gnt}), 32'b01);
        tick(); applyStimulus(0, 0, 0, 0, 0);
        @(negedge clk); checkOutput("wc1_m1_second", 32'(m1_gnt), 1);
        tick(); applyStimulus(1, 0, 0, 0, 0); applyStimulus(0, 1, 0, 7'd10, 8'h00);
        @(negedge clk);
        tick(); applyStimulus(0, 0, 0, 0, 0);
        @(negedge clk); checkOutput("wc1_readback", 32'(m0_rdata), 32'h22);
        tick(); applyStimulus(0, 1, 1, 7'd10, 8'h33); applyStimulus(1, 1, 1, 7'd10, 8'h44);
        @(negedge clk);
        checkOutput("wc2_m1_first", 32'({m1_gnt, m0_gnt}), 32'b10);
        tick(); applyStimulus(1, 0, 0, 0, 0);
        @(negedge clk); checkOutput("wc2_m0_second", 32'(m0_gnt), 1);
        tick(); applyStimulus(0, 0, 0, 0, 0);

        // Continuous read contention: grants alternate starting with m0.
        applyStimulus(0, 1, 0, 7'd5, 8'h00); applyStimulus(1, 1, 0, 7'd10, 8'h00);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("rc_m0_gnt", 32'(m0_gnt), 32'(i % 2 == 0));
            checkOutput("rc_m1_gnt", 32'(m1_gnt), 32'(i % 2 == 1));
            if (i > 0) checkOutput("rc_m0_rvalid", 32'(m0_rvalid), 32'(i % 2 == 1));
            tick();
        end
        applyStimulus(0, 0, 0, 0, 0); applyStimulus(1, 0, 0, 0, 0);
        @(negedge clk);

        // Parallel write and read ports, then same-address write-first.
        tick(); applyStimulus(0, 1, 1, 7'd22, 8'd44);
        @(negedge clk);
        tick(); applyStimulus(0, 1, 1, 7'd33, 8'd33); applyStimulus(1, 1, 0, 7'd22, 8'h00);
        @(negedge clk); checkOutput("par_both_gnt", 32'({m1_gnt, m0_gnt}), 32'b11);
        tick(); applyStimulus(0, 0, 0, 0, 0); applyStimulus(1, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("par_m1_rvalid", 32'(m1_rvalid), 1);
        checkOutput("par_m1_data", 32'(m1_rdata), 32'd44);
        tick(); applyStimulus(1, 1, 0, 7'd33, 8'h00);
        @(negedge clk);
        tick(); applyStimulus(1, 0, 0, 0, 0);
        @(negedge clk); checkOutput("par_rd33", 32'(m1_rdata), 32'd33);
        tick(); applyStimulus(0, 1, 1, 7'd7, 8'h7E); applyStimulus(1, 1, 0, 7'd7, 8'h00);
        @(negedge clk);
        tick(); applyStimulus(0, 0, 0, 0, 0); applyStimulus(1, 0, 0, 0, 0);
        @(negedge clk); checkOutput("same_addr_write_first", 32'(m1_rdata), 32'h7E);

        // Reset right after a read grant drops the read and clears the RAM.
        tick(); applyStimulus(0, 1, 0, 7'd5, 8'h00);
        @(negedge clk); checkOutput("rst_rd_gnt", 32'(m0_gnt), 1);
        tick(); rst_n = 1'b0; applyStimulus(0, 0, 0, 0, 0);
        @(negedge clk); checkOutput("rst_drops_rvalid", 32'(m0_rvalid), 0);
        bringUp();
        tick(); applyStimulus(0, 1, 0, 7'd5, 8'h00);
        @(negedge clk);
        tick(); applyStimulus(0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("rst_cleared_rvalid", 32'(m0_rvalid), 1);
        checkOutput("rst_cleared_data", 32'(m0_rdata), 0);

        // Randomized traffic; requesters hold until granted, ready flickers, one reset mid-run.
        for (int c = 0; c < 3000; c++) begin
            tick();
            ram_ready = ($urandom_range(0, 9) != 0);
            if (c == 1500) rst_n = 1'b0;
            if (c == 1503) rst_n = 1'b1;
            if (!m0_req || gnt_seen0) begin
                if ($urandom_range(0, 2) != 0)
                    applyStimulus(0, 1, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 15)), 8'($urandom));
                else
                    applyStimulus(0, 0, 0, 0, 0);
            end
            if (!m1_req || gnt_seen1) begin
                if ($urandom_range(0, 2) != 0)
                    applyStimulus(1, 1, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 15)), 8'($urandom));
                else
                    applyStimulus(1, 0, 0, 0, 0);
            end
        end
        tick();
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Controller placed in front of the dual-port RAM; shares its one write port and one read port between two requesters (m0, m1).
- Arbitrates the write and read ports independently, each with its own round-robin pointer.
- Sequences the RAM's reset and valid/ready bring-up, and returns read data to the granted requester tagged with a valid strobe.

Parameters:
MEM_DEPTH, 128, RAM depth in words
ADDR_WIDTH, $clog2(MEM_DEPTH), address width
DATA_WIDTH, 8, word width
RST_CYCLES, 2, cycles ram_rst_o is held high after reset release

Ports:
clk_i  in  1  single clock, rising edge
rst_n_i  in  1  reset, asynchronous, active-low
mK_req_i  in  1  request from requester K (K=0,1), held until granted
mK_we_i  in  1  1=write, 0=read
mK_addr_i  in  ADDR_WIDTH  request address
mK_wdata_i  in  DATA_WIDTH  write data
mK_gnt_o  out  1  request accepted this cycle (combinational)
mK_rvalid_o  out  1  read data valid for K
mK_rdata_o  out  DATA_WIDTH  read data (equals ram_rd_data_i)
ram_rst_o  out  1  sync active-high reset to RAM
ram_valid_o  out  1  RAM valid
ram_ready_i  in  1  RAM ready
ram_wr_en_o, ram_rd_en_o  out  1  port enables
ram_wr_addr_o, ram_rd_addr_o  out  ADDR_WIDTH  port addresses
ram_wr_data_o  out  DATA_WIDTH  write data
ram_rd_data_i  in  DATA_WIDTH  RAM registered read data
init_done_o  out  1  high in RUN

Behaviour:
- Reset (rst_n_i=0, async): state=RST, counter=0, both RR pointers=0 (m0 favoured), rd_pending=0.
- Reset outputs: ram_rst_o=1, ram_valid_o=0, all gnt/rvalid/enables=0, init_done_o=0.
- FSM RST: ram_rst_o=1 for RST_CYCLES cycles, then go to WAIT_RDY.
- FSM WAIT_RDY: ram_rst_o=0, ram_valid_o=1; go to RUN on the first cycle ram_ready_i=1.
- FSM RUN: ram_valid_o=1, init_done_o=1. There is no exit except reset.
- Grants are issued only in RUN with ram_ready_i=1; otherwise all gnt=0 and enables=0.
- Write port: the candidate set is requesters with req&we.
  - One candidate: grant it.
  - Two candidates: grant the one favoured by wr_ptr.
  - After a contested grant, wr_ptr points to the loser. An uncontested grant leaves wr_ptr unchanged.
- Read port: same rules with req&!we and rd_ptr.
- Write and read are independent: m0 write plus m1 read (or the reverse) are both granted in the same cycle.
- A granted write drives ram_wr_en_o=1 with the winner's addr/data in the same cycle. It completes at that edge.
- A granted read drives ram_rd_en_o=1 and ram_rd_addr_o in the same cycle. On that edge, rd_pending<=1 and rd_owner<=winner.
- Next cycle: rvalid_o=1 for rd_owner only, with rdata=ram_rd_data_i. Read latency is 1 cycle from grant.
- Back-to-back reads give rvalid every cycle.
- The loser keeps req asserted; the requester must not change addr/data/we while req=1 and gnt=0.
- A requester asserting req holds it until it sees gnt; it is served within 2 cycles of the port being free (fairness).
- Same-address write+read in the same cycle: the read returns the NEW data (write-first RAM semantics). The arbiter adds no bypass.
- ram_ready_i=0 in RUN: grants and enables are blocked. An already-issued pending read still returns its rvalid.
- Async reset mid-operation: the pending read is dropped (no rvalid) and the FSM restarts at RST, so RAM contents are cleared again.

Test Plan:
- Bring-up: release rst_n_i -> ram_rst_o high exactly 2 cycles; ram_valid_o=1, then ready seen; init_done_o=1; req before RUN gets no gnt.
- Single write/read: m0 writes addr 5 data 0xA5; next cycle m0 reads addr 5 -> m0_gnt same cycle; m0_rvalid one cycle later with rdata=0xA5; m1_rvalid stays 0.
- Write contention: m0 and m1 both write addr 10 (0x11 / 0x22) and hold req -> m0 granted first, m1 next cycle; readback of addr 10 = 0x22. Repeat the contention -> m1 now wins first.
- Read contention with continuous requests for 8 cycles: both masters read -> grants alternate m0,m1,m0,...; each rvalid is routed to the correct owner with the correct data.
- Parallel ports: m0 writes addr 33 data 33 while m1 reads addr 22 (preloaded 44) -> both granted the same cycle; m1 rdata=44; then read addr 33 -> 33. Same-address write 0x7E plus read of addr 7 -> read returns 0x7E.
- Reset mid-read: assert rst_n_i the cycle after a read grant -> no rvalid; after bring-up, read of any previously written address returns 0.
